instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 122 ++++++++++++
 tb/tb_instr_fetch.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: drives the ROM address, queues returned words in a 2-deep buffer, handles redirects and optional HALT.
// Latency: the first word appears 2 cycles after reset release or redirect; then one word per cycle at full rate.
// Backpressure: instr_ready=0 holds the head stable; fetch issue stops once buffer plus in-flight reach 2 entries.
// Build option: define IFETCH_HALT_EN so that an opcode 4'hF word stops fetching and raises halted.
module instr_fetch (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic [15:0] instr,
  output logic [7:0]  instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_en,
  input  logic [7:0]  branch_addr,
  output logic        halted
);

  typedef struct packed {
    logic [15:0] word;
    logic [7:0]  pc;
  } entry_t;

  logic [7:0] pc_q;
  logic       inflight_q;
  logic [7:0] inflight_pc_q;
  entry_t     ent0_q, ent1_q, ent0_d, ent1_d, new_ent;
  logic [1:0] cnt_q, cnt_d;
  logic       pop, push, stop, issue;
  logic [2:0] occ;

`ifdef IFETCH_HALT_EN
  logic halted_q;
  logic halt_now;

  // A word returning after HALT has been written is dropped; a HALT word being written stops issue immediately.
  always_comb begin
    push     = inflight_q & ~halted_q;
    halt_now = push & (rom_data[15:12] == 4'hF);
    stop     = halted_q | halt_now;
  end

  // Halt flag: set by a written HALT word, cleared by reset or redirect.
  always_ff @(posedge clk) begin
    if (!rst)          halted_q <= 1'b0;
    else if (branch_en) halted_q <= 1'b0;
    else if (halt_now)  halted_q <= 1'b1;
  end

  assign halted = halted_q;
`else
  assign push   = inflight_q;
  assign stop   = 1'b0;
  assign halted = 1'b0;
`endif

  assign pop         = (cnt_q != 2'd0) & instr_ready;
  assign occ         = {1'b0, cnt_q} + {2'b00, inflight_q};
  assign issue       = ~branch_en & ~stop & (occ < (3'd2 + {2'b00, pop}));
  assign new_ent     = '{word: rom_data, pc: inflight_pc_q};
  assign rom_addr    = pc_q;
  assign instr       = ent0_q.word;
  assign instr_pc    = ent0_q.pc;
  assign instr_valid = (cnt_q != 2'd0);

  // Buffer next state: head shifts forward on pop, returning word lands in the first free slot.
  always_comb begin
    cnt_d  = cnt_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          ent0_d = new_ent;
          cnt_d  = 2'd1;
        end else begin
          ent1_d = new_ent;
          cnt_d  = 2'd2;
        end
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = new_ent;
        end else begin
          ent0_d = ent1_q;
          ent1_d = new_ent;
        end
      end
      default: ;
    endcase
  end

  // Fetch PC, in-flight tracking and buffer state; a redirect flushes and squashes before anything else.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q          <= 8'h00;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 8'h00;
      cnt_q         <= 2'd0;
      ent0_q        <= '0;
      ent1_q        <= '0;
    end else if (branch_en) begin
      pc_q       <= branch_addr;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q          <= pc_q + 8'd1;
        inflight_pc_q <= pc_q;
      end
      cnt_q  <= cnt_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_en;
  logic [7:0]  branch_addr;
  logic        halted;

  logic [15:0] rom [256];
  int n_cmp = 0;
  int n_err = 0;

  instr_fetch dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .branch_en(branch_en), .branch_addr(branch_addr),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // ROM with one cycle read latency
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; instr_ready = 1'b1; branch_en = 1'b0; branch_addr = 8'h00;
    step(); step(); step();
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0h want 0", instr_valid); end
    n_cmp++; if (instr !== 16'h0000) begin n_err++; $display("FAIL rst_instr got %h want 0000", instr); end
    n_cmp++; if (instr_pc !== 8'h00) begin n_err++; $display("FAIL rst_pc got %h want 00", instr_pc); end
    n_cmp++; if (rom_addr !== 8'h00) begin n_err++; $display("FAIL rst_addr got %h want 00", rom_addr); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted got %0h want 0", halted); end
    rst = 1'b1;
    step();
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rel1_valid got %0h want 0", instr_valid); end
    n_cmp++; if (rom_addr !== 8'h01) begin n_err++; $display("FAIL rel1_addr got %h want 01", rom_addr); end
    step();
    n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL rel2_valid got %0h want 1", instr_valid); end
    n_cmp++; if (instr_pc !== 8'h00) begin n_err++; $display("FAIL rel2_pc got %h want 00", instr_pc); end
  endtask

  task automatic test_stream();
    instr_ready = 1'b1;
    do_reset();
    step(); step();
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %0h want 1", i, instr_valid); end
      n_cmp++; if (instr_pc !== 8'(i)) begin n_err++; $display("FAIL stream_pc[%0d] got %h want %h", i, instr_pc, 8'(i)); end
      n_cmp++; if (instr !== 16'(i * 16'h0101)) begin n_err++; $display("FAIL stream_instr[%0d] got %h want %h", i, instr, 16'(i * 16'h0101)); end
      step();
    end
  endtask

  task automatic test_stall();
    instr_ready = 1'b1;
    do_reset();
    step(); step();
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (instr !== 16'h0000 || instr_valid !== 1'b1) begin n_err++; $display("FAIL stall_head[%0d] got %h/%0h want 0000/1", i, instr, instr_valid); end
      n_cmp++; if (rom_addr !== 8'h02) begin n_err++; $display("FAIL stall_addr[%0d] got %h want 02", i, rom_addr); end
    end
    instr_ready = 1'b1;
    n_cmp++; if (instr !== 16'h0000) begin n_err++; $display("FAIL release0 got %h want 0000", instr); end
    for (int i = 1; i < 4; i++) begin
      step();
      n_cmp++; if (instr_valid !== 1'b1 || instr !== 16'(i * 16'h0101)) begin n_err++; $display("FAIL release[%0d] got %h/%0h want %h/1", i, instr, instr_valid, 16'(i * 16'h0101)); end
    end
  endtask

  task automatic test_branch();
    instr_ready = 1'b0;
    do_reset();
    step(); step(); step();
    n_cmp++; if (rom_addr !== 8'h02) begin n_err++; $display("FAIL br_full_addr got %h want 02", rom_addr); end
    branch_en = 1'b1; branch_addr = 8'h40;
    step();
    branch_en = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL br_c1_valid got %0h want 0", instr_valid); end
    n_cmp++; if (rom_addr !== 8'h40) begin n_err++; $display("FAIL br_c1_addr got %h want 40", rom_addr); end
    step();
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL br_c2_valid got %0h want 0", instr_valid); end
    step();
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 8'h40) begin n_err++; $display("FAIL br_first got %h/%0h want 40/1", instr_pc, instr_valid); end
    n_cmp++; if (instr !== 16'h4040) begin n_err++; $display("FAIL br_first_instr got %h want 4040", instr); end
    instr_ready = 1'b1;
    step();
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 8'h41) begin n_err++; $display("FAIL br_next got %h/%0h want 41/1", instr_pc, instr_valid); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc [4];
    exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00; exp_pc[3] = 8'h01;
    instr_ready = 1'b1;
    do_reset();
    step(); step(); step();
    branch_en = 1'b1; branch_addr = 8'hFE;
    step();
    branch_en = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL wrap_flush got %0h want 0", instr_valid); end
    step(); step();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc[i]) begin n_err++; $display("FAIL wrap_pc[%0d] got %h/%0h want %h/1", i, instr_pc, instr_valid, exp_pc[i]); end
      n_cmp++; if (instr !== {exp_pc[i], exp_pc[i]}) begin n_err++; $display("FAIL wrap_instr[%0d] got %h want %h", i, instr, {exp_pc[i], exp_pc[i]}); end
      step();
    end
  endtask

  task automatic test_mid_reset();
    instr_ready = 1'b1;
    do_reset();
    step(); step(); step();
    instr_ready = 1'b0;
    step(); step();
    n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL mr_pre_valid got %0h want 1", instr_valid); end
    rst = 1'b0;
    step();
    rst = 1'b1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL mr_valid got %0h want 0", instr_valid); end
    n_cmp++; if (rom_addr !== 8'h00 || instr !== 16'h0000) begin n_err++; $display("FAIL mr_state got %h/%h want 00/0000", rom_addr, instr); end
    instr_ready = 1'b1;
    step();
    n_cmp++; if (instr_valid !== 1'b0 || rom_addr !== 8'h01) begin n_err++; $display("FAIL mr_rel1 got %0h/%h want 0/01", instr_valid, rom_addr); end
    step();
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 8'h00) begin n_err++; $display("FAIL mr_rel2 got %0h/%h want 1/00", instr_valid, instr_pc); end
  endtask

  task automatic test_halt();
    rom[3] = 16'hF000;
    instr_ready = 1'b1;
    do_reset();
    step(); step();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 8'(i)) begin n_err++; $display("FAIL halt_pc[%0d] got %h/%0h want %h/1", i, instr_pc, instr_valid, 8'(i)); end
      if (i < 3) step();
    end
    n_cmp++; if (instr !== 16'hF000) begin n_err++; $display("FAIL halt_word got %h want f000", instr); end
`ifdef IFETCH_HALT_EN
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_flag got %0h want 1", halted); end
    n_cmp++; if (rom_addr !== 8'h04) begin n_err++; $display("FAIL halt_addr got %h want 04", rom_addr); end
    step(); step(); step();
    n_cmp++; if (instr_valid !== 1'b0 || rom_addr !== 8'h04 || halted !== 1'b1) begin n_err++; $display("FAIL halt_frozen got %0h/%h/%0h want 0/04/1", instr_valid, rom_addr, halted); end
    branch_en = 1'b1; branch_addr = 8'h10;
    step();
    branch_en = 1'b0;
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_clear got %0h want 0", halted); end
    step(); step();
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 8'h10) begin n_err++; $display("FAIL halt_resume got %0h/%h want 1/10", instr_valid, instr_pc); end
`else
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL nohalt_flag got %0h want 0", halted); end
    step();
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 8'h04 || instr !== 16'h0404) begin n_err++; $display("FAIL nohalt_next got %0h/%h/%h want 1/04/0404", instr_valid, instr_pc, instr); end
`endif
    rom[3] = 16'h0303;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'(i * 16'h0101);
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_wrap();
    test_mid_reset();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
